rr_burst_arbiter: RTL and testbench
===================================

Name: rr_burst_arbiter

Overview:
Parametrised successor to the fixed-priority input arbiter used in the arbiter/router fabric. It picks one of ninputs val/rdy streams using round-robin priority. A granted input may keep the grant for a burst of up to max_burst back-to-back messages. The winning message is registered in a one-entry output stage, tagged with its source index, and presented on ostream as {addr, data}, feeding the router or a downstream FIFO.

Parameters:
nbits, 32, data width of each input message
ninputs, 4, number of input streams (≥2)
max_burst, 4, max consecutive transfers granted to one input before priority rotates (≥1; 1 = pure round-robin)
addr_nbits (localparam), $clog2(ninputs), source-index field width
cnt_nbits (localparam), $clog2(max_burst+1), burst counter width

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous active-low reset
istream_val  input  ninputs  per-input valid; bit i = input i
istream_rdy  output  ninputs  per-input ready; at most one bit high
istream_msg  input  ninputs*nbits  input i at bits [i*nbits +: nbits]
ostream_val  output  1  output register holds a message
ostream_rdy  input  1  downstream ready
ostream_msg  output  addr_nbits+nbits  {source index, data} from output register

Behaviour:
- State: out_val, out_msg (output register); last_idx (addr_nbits); burst_cnt (cnt_nbits).
- Reset (reset=0, async): out_val=0, out_msg=0, last_idx=ninputs-1, burst_cnt=0. So ostream_val=0 and istream_rdy=0 while in reset.
- accept = !out_val | ostream_rdy. This is combinational, so ready passes through from ostream_rdy to istream_rdy.
- Grant g, combinational, evaluated every cycle:
  - If burst_cnt≠0, burst_cnt<max_burst and istream_val[last_idx], then g=last_idx (lock held).
  - Otherwise g = first i with istream_val[i], scanning cyclically from (last_idx+1) mod ninputs. last_idx is checked last.
  - If no valid input, there is no grant.
- istream_rdy[g] = accept. All other istream_rdy bits are 0, and all bits are 0 when there is no grant.
- Transfer when istream_val[g] & istream_rdy[g]. On that edge:
  - out_msg ← {g, msg_g}; out_val ← 1.
  - If the grant came from the lock: burst_cnt ← burst_cnt+1. Otherwise burst_cnt ← 1.
  - last_idx ← g.
- No input transfer but ostream fire (ostream_val & ostream_rdy): out_val ← 0.
- Simultaneous ostream fire and input transfer: the register is overwritten with the new message and out_val stays 1. This sustains full throughput, 1 message/cycle.
- Latency: 1 cycle from input handshake to ostream_val.
- No transfer: last_idx and burst_cnt hold. This covers stalls (accept=0, all rdy low) and idle cycles. A lock therefore survives idle and stalled cycles.
- The lock breaks when:
  - the locked input drops val while another input is valid (rotate to the next valid input after last_idx); or
  - burst_cnt reaches max_burst.
- Sole valid input after its burst expires: it is re-granted via the scan and burst_cnt restarts at 1. There is no starvation of a lone requester.
- Index arithmetic wraps modulo ninputs; non-power-of-2 ninputs must be correct.
- The output register is stable while ostream_val=1 and ostream_rdy=0.
- Reset asserted mid-burst or while out_val=1 discards the held message and restores reset state immediately.

Test Plan:
- Reset/idle: hold reset=0, then release with all val=0. ostream_val=0, istream_rdy=0000, no state change for 10 cycles.
- Pure round-robin: max_burst=1, all four inputs continuously valid with msg=0xA0+i, ostream_rdy=1. ostream_msg addr sequence is 0,1,2,3,0,… one message per cycle, data 0xA0,0xA1,….
- Burst lock: max_burst=4, inputs 1 and 2 always valid. Output addr sequence is 1,1,1,1,2,2,2,2,1,…
- Early lock break: input 0 valid for 2 messages then drops val; input 3 valid throughout; max_burst=4. Addrs are 0,0,3,3,3,3, then 0 again once input 0 is valid.
- Backpressure: ostream_rdy=0 for 5 cycles with input 2 valid. Exactly one message is captured, ostream_msg is stable, istream_rdy=0000. On ostream_rdy=1 the stream resumes with no loss or duplication, and burst_cnt continues from its held value.
- Reset mid-operation: assert reset while out_val=1 and burst_cnt=2. ostream_val drops immediately. After release the first grant goes to the lowest valid index scanning from 0.

Source files
------------

// File: rtl/rr_burst_arbiter.sv
// Round-robin val/rdy arbiter with burst locking and a one-entry output register
// carrying {source index, data}.
`timescale 1ns/1ps

module rr_burst_arbiter_lane #(
  parameter int nbits = 32
) (
  input  logic             val,
  input  logic             sel,
  input  logic             accept,
  input  logic [nbits-1:0] msg,
  output logic             rdy,
  output logic             xfer,
  output logic [nbits-1:0] msg_sel
);
  assign rdy     = sel & accept;
  assign xfer    = val & rdy;
  assign msg_sel = sel ? msg : '0;
endmodule

module rr_burst_arbiter #(
  parameter  int nbits      = 32,
  parameter  int ninputs    = 4,
  parameter  int max_burst  = 4,
  localparam int addr_nbits = $clog2(ninputs),
  localparam int cnt_nbits  = $clog2(max_burst + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [ninputs-1:0]            istream_val,
  output logic [ninputs-1:0]            istream_rdy,
  input  logic [ninputs*nbits-1:0]      istream_msg,
  output logic                          ostream_val,
  input  logic                          ostream_rdy,
  output logic [addr_nbits+nbits-1:0]   ostream_msg
);
  logic                         out_val;
  logic [addr_nbits+nbits-1:0]  out_msg;
  logic [addr_nbits-1:0]        last_idx, grant;
  logic [cnt_nbits-1:0]         burst_cnt;
  logic                         has_grant, lock, accept, xfer;
  logic [ninputs-1:0][nbits-1:0] msg_a, msg_sel;
  logic [ninputs-1:0]           xfer_vec;
  logic [nbits-1:0]             grant_msg;

  assign msg_a  = istream_msg;
  // Ready is held low while reset is asserted so nothing handshakes in reset.
  assign accept = reset & (~out_val | ostream_rdy);
  assign lock   = (burst_cnt != '0) && (burst_cnt < cnt_nbits'(max_burst))
                  && istream_val[last_idx];

  // Cyclic scan starting after last_idx; last_idx itself is considered last.
  always_comb begin
    grant     = last_idx;
    has_grant = lock;
    if (!lock) begin
      for (int k = 1; k <= ninputs; k++) begin
        if (!has_grant && istream_val[(int'(last_idx) + k) % ninputs]) begin
          has_grant = 1'b1;
          grant     = addr_nbits'((int'(last_idx) + k) % ninputs);
        end
      end
    end
  end

  for (genvar i = 0; i < ninputs; i++) begin : g_lane
    rr_burst_arbiter_lane #(.nbits(nbits)) u_lane (
      .val     (istream_val[i]),
      .sel     (has_grant && (grant == addr_nbits'(i))),
      .accept  (accept),
      .msg     (msg_a[i]),
      .rdy     (istream_rdy[i]),
      .xfer    (xfer_vec[i]),
      .msg_sel (msg_sel[i])
    );
  end

  always_comb begin
    grant_msg = '0;
    for (int i = 0; i < ninputs; i++) grant_msg = grant_msg | msg_sel[i];
  end

  assign xfer = |xfer_vec;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_val   <= 1'b0;
      out_msg   <= '0;
      last_idx  <= addr_nbits'(ninputs - 1);
      burst_cnt <= '0;
    end else if (xfer) begin
      out_val   <= 1'b1;
      out_msg   <= {grant, grant_msg};
      last_idx  <= grant;
      burst_cnt <= lock ? burst_cnt + cnt_nbits'(1) : cnt_nbits'(1);
    end else if (ostream_rdy) begin
      out_val   <= 1'b0;
    end
  end

  assign ostream_val = out_val;
  assign ostream_msg = out_msg;
endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Bench for rr_burst_arbiter: per-cycle vector table plus scoreboarded output stream.
`timescale 1ns/1ps

module tb_rr_burst_arbiter;
  localparam int NB = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] val4, rdy4, val1, rdy1;
  logic [2:0] val3, rdy3;
  logic [4*NB-1:0] msg4, msg1;
  logic [3*NB-1:0] msg3;
  logic ov4, or4, ov1, or1, ov3, or3;
  logic [9:0] om4, om1, om3;

  assign msg4 = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
  assign msg1 = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
  assign msg3 = {8'hA2, 8'hA1, 8'hA0};

  rr_burst_arbiter #(.nbits(NB), .ninputs(4), .max_burst(4)) u4 (
    .clk(clk), .reset(reset), .istream_val(val4), .istream_rdy(rdy4),
    .istream_msg(msg4), .ostream_val(ov4), .ostream_rdy(or4), .ostream_msg(om4));
  rr_burst_arbiter #(.nbits(NB), .ninputs(4), .max_burst(1)) u1 (
    .clk(clk), .reset(reset), .istream_val(val1), .istream_rdy(rdy1),
    .istream_msg(msg1), .ostream_val(ov1), .ostream_rdy(or1), .ostream_msg(om1));
  rr_burst_arbiter #(.nbits(NB), .ninputs(3), .max_burst(2)) u3 (
    .clk(clk), .reset(reset), .istream_val(val3), .istream_rdy(rdy3),
    .istream_msg(msg3), .ostream_val(ov3), .ostream_rdy(or3), .ostream_msg(om3));

  int n_chk = 0, n_pass = 0;
  logic [9:0] q4[$], q1[$], q3[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [9:0] em(input int i);
    return {2'(i), 8'(8'hA0 + i)};
  endfunction

  function automatic int oh2i(input logic [3:0] oh);
    int r = 0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = i;
    return r;
  endfunction

  // Scoreboard monitors: pop one expected message per output handshake.
  always @(negedge clk) if (reset && ov4 && or4) begin
    if (q4.size() == 0) begin n_chk++; $display("FAIL u4 msg: got %0h expected none", om4); end
    else chk("u4 msg", om4, q4.pop_front());
  end
  always @(negedge clk) if (reset && ov1 && or1) begin
    if (q1.size() == 0) begin n_chk++; $display("FAIL u1 msg: got %0h expected none", om1); end
    else chk("u1 msg", om1, q1.pop_front());
  end
  always @(negedge clk) if (reset && ov3 && or3) begin
    if (q3.size() == 0) begin n_chk++; $display("FAIL u3 msg: got %0h expected none", om3); end
    else chk("u3 msg", om3, q3.pop_front());
  end

  typedef struct {
    logic [3:0] val;
    logic       ordy;
    logic [3:0] rdy;
    logic       oval;
    logic       cm;
    logic [9:0] msg;
  } vec_t;
  vec_t tab[$];

  task automatic add(input logic [3:0] v, input logic o, input logic [3:0] r,
                     input logic ov, input int n = 1, input logic cm = 1'b0,
                     input logic [9:0] m = '0);
    vec_t e;
    e.val = v; e.ordy = o; e.rdy = r; e.oval = ov; e.cm = cm; e.msg = m;
    repeat (n) tab.push_back(e);
  endtask

  initial begin
    val4 = '0; val1 = '0; val3 = '0;
    or4 = 1'b1; or1 = 1'b1; or3 = 1'b1;

    // early lock break: input 0 for two, then input 3 for a full burst
    add(4'b1001, 1, 4'b0001, 0);
    add(4'b1001, 1, 4'b0001, 1);
    add(4'b1000, 1, 4'b1000, 1, 4);
    add(4'b1001, 1, 4'b0001, 1);
    add(4'b0000, 1, 4'b0000, 1);
    // burst lock: inputs 1 and 2
    add(4'b0110, 1, 4'b0010, 0);
    add(4'b0110, 1, 4'b0010, 1, 3);
    add(4'b0110, 1, 4'b0100, 1, 4);
    add(4'b0110, 1, 4'b0010, 1);
    add(4'b0000, 1, 4'b0000, 1);
    // backpressure with input 2, then input 3 joins after the stall
    add(4'b0100, 0, 4'b0100, 0);
    add(4'b0100, 0, 4'b0000, 1, 4, 1'b1, em(2));
    add(4'b1100, 1, 4'b0100, 1, 3);
    add(4'b1100, 1, 4'b1000, 1);
    add(4'b0000, 1, 4'b0000, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("reset oval", ov4, 0);
    chk("reset rdy", rdy4, 0);
    reset = 1'b1;

    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("idle%0d oval", k), ov4, 0);
      chk($sformatf("idle%0d rdy", k), rdy4, 0);
    end
    @(posedge clk); #1;

    // round robin on max_burst=1 (4 inputs) and max_burst=2 (3 inputs)
    for (int k = 0; k < 8; k++) begin
      val1 = 4'hF; val3 = 3'h7;
      q1.push_back(em(k % 4));
      q3.push_back(em((k / 2) % 3));
      @(negedge clk);
      chk($sformatf("rr1 %0d rdy", k), rdy1, 32'(1) << (k % 4));
      chk($sformatf("rr3 %0d rdy", k), rdy3, 32'(1) << ((k / 2) % 3));
      @(posedge clk); #1;
    end
    val1 = '0; val3 = '0;
    @(posedge clk); #1;

    foreach (tab[k]) begin
      val4 = tab[k].val; or4 = tab[k].ordy;
      if (tab[k].rdy != 0) q4.push_back(em(oh2i(tab[k].rdy)));
      @(negedge clk);
      chk($sformatf("row%0d rdy", k), rdy4, tab[k].rdy);
      chk($sformatf("row%0d oval", k), ov4, tab[k].oval);
      if (tab[k].cm) chk($sformatf("row%0d stable msg", k), om4, tab[k].msg);
      @(posedge clk); #1;
    end

    // reset mid-burst with a message held
    val4 = 4'b0010; or4 = 1'b0;
    q4.push_back(em(1));
    @(negedge clk);
    chk("mid0 rdy", rdy4, 4'b0010);
    @(posedge clk); #1;
    or4 = 1'b1;
    @(negedge clk);
    chk("mid1 rdy", rdy4, 4'b0010);
    chk("mid1 oval", ov4, 1);
    @(posedge clk); #1;
    chk("pre-reset oval", ov4, 1);
    reset = 1'b0;
    #1;
    chk("async reset oval", ov4, 0);
    chk("async reset rdy", rdy4, 0);
    val4 = 4'b0101;
    @(posedge clk); @(posedge clk); #1;
    chk("in reset rdy", rdy4, 0);
    reset = 1'b1;
    q4.push_back(em(0));
    @(negedge clk);
    chk("post-reset rdy", rdy4, 4'b0001);
    chk("post-reset oval", ov4, 0);
    @(posedge clk); #1;
    val4 = '0;
    @(negedge clk);
    chk("post-reset out", ov4, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("q4 drained", q4.size(), 0);
    chk("q1 drained", q1.size(), 0);
    chk("q3 drained", q3.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
